rgb_led_stream_arbiter: RTL and testbench
=========================================

# rgb_led_stream_arbiter

Shares one 24-bit Avalon-ST RGB LED sink among N_SRC Avalon-ST pattern sources, such as fade generators, CPU-written colour, and alarm blink. It uses round-robin arbitration with a programmable grant hold time, so each source owns the LED for a visible interval. It sits between the pattern generators and the LED PWM/driver stage. An Avalon-MM slave provides the enable mask, hold length and status.

## Interface
Parameters:
- N_SRC, 4, number of requesting sources (2..8)
- HOLD_W, 24, width of hold counter/register
- HOLD_DEFAULT, 24'h07FFFF, reset value of hold register (cycles)

Ports:
- csi_MCLK_clk  in  1  clock; all logic on rising edge
- rsi_MRST_reset_n  in  1  reset, asynchronous assert, active-low
- asi_SRC_data  in  N_SRC*24  source k at [24k+23:24k], {R,G,B}
- asi_SRC_valid  in  N_SRC  per-source valid
- asi_SRC_ready  out  N_SRC  per-source ready
- aso_LEDS_data  out  24  granted source data, {R,G,B}
- aso_LEDS_valid  out  1  granted source valid
- aso_LEDS_ready  in  1  sink ready
- avs_CTRL_address  in  2  register select
- avs_CTRL_write  in  1  write strobe
- avs_CTRL_writedata  in  32  write data
- avs_CTRL_read  in  1  read strobe
- avs_CTRL_readdata  out  32  read data, combinational, read latency 0, no waitrequest

## Operation
- Registers:
  - addr 0 ENABLE, bits [N_SRC-1:0], reset all ones.
  - addr 1 HOLD, bits [HOLD_W-1:0], reset HOLD_DEFAULT; 0 = unlimited hold.
  - addr 2 STATUS (RO): bit 31 busy, bits [2:0] grant index.
  - addr 3 XFER_CNT (RO 16-bit count of completed transfers, saturating at 16'hFFFF); any write to addr 3 clears it.
  - Unused bits read 0; writes to addr 2 are ignored.
- Request of source k = asi_SRC_valid[k] & ENABLE[k].
- State IDLE:
  - aso_LEDS_valid=0, aso_LEDS_data=0, all asi_SRC_ready=0.
  - If any request: pick first requester searching from last_grant+1 upward (wrap modulo N_SRC), latch grant, load hold_cnt=HOLD, go GRANT.
- State GRANT (grant g):
  - aso_LEDS_data/valid = source g data/valid; asi_SRC_ready[g]=aso_LEDS_ready; other readies 0. This path is combinational.
  - hold_cnt decrements by 1 each cycle when HOLD≠0; it does not wrap below 0.
  - Go RELEASE when any of these holds: asi_SRC_valid[g]=0; ENABLE[g]=0; HOLD≠0 and hold_cnt==1.
- State RELEASE (1 cycle): outputs as IDLE, last_grant=g, go IDLE. The guaranteed gap lets the sink see a source boundary.
- XFER_CNT increments on each cycle with aso_LEDS_valid & aso_LEDS_ready.
- A HOLD write during GRANT affects only the next grant. An ENABLE write takes effect the next cycle.
- Reset mid-grant: immediate return to IDLE; last_grant=N_SRC-1, so source 0 has first priority after reset.
- Outputs at reset: aso_LEDS_valid=0, aso_LEDS_data=0, asi_SRC_ready=0, busy=0, grant index=0, XFER_CNT=0.

## Timing
- Request to grant: 1 cycle. A request seen in IDLE at edge n gives aso_LEDS_valid in cycle n+1.
- Hold length: with HOLD=H≥1 and continuous valid, GRANT lasts exactly H cycles. RELEASE adds 1 cycle and IDLE adds 1 cycle before the next GRANT, so the period per source is H+2.
- A valid drop is seen in the same cycle; the transition takes effect at the next edge.
- Simultaneous register write and release: the register updates, and the release uses pre-write values.
- busy=1 in GRANT only.

## Structure
- Package rgb_led_arb_pkg holds:
  - state enum {IDLE, GRANT, RELEASE};
  - register address constants ADDR_ENABLE/HOLD/STATUS/XFER;
  - XFER_W=16.
- Sub-module rgb_led_rr_pick is combinational: request vector plus last_grant in, one-hot/index plus any_req out. The rest is one sequential module.

## Test plan
- Reset then sources 0 and 2 valid, HOLD=4 → grant 0 for 4 cycles, RELEASE, IDLE, grant 2 for 4 cycles, then grant 0 again.
- HOLD=0, source 1 valid continuously → grant 1 held indefinitely. Deassert valid → RELEASE next cycle, aso_LEDS_valid=0.
- ENABLE=4'b1011 with all sources valid → source 2 never granted; order is 0,1,3,0.
- aso_LEDS_ready toggled 1010 during a 6-cycle grant → asi_SRC_ready[g] mirrors it, other readies 0; XFER_CNT=3. Write addr 3 → reads 0.
- Assert rsi_MRST_reset_n low mid-grant of source 3 → all outputs 0 immediately. After release with all sources valid, the first grant is source 0.
- Write HOLD=2 during a grant with HOLD=8 → current grant lasts 8 cycles, next grant lasts 2.

Source files
------------

// File: rtl/rgb_led_arb_pkg.sv
// Shared types and constants for the RGB LED stream arbiter.
package rgb_led_arb_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } arb_state_e;

    // Control register map
    localparam logic [1:0] ADDR_ENABLE = 2'd0;
    localparam logic [1:0] ADDR_HOLD   = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;
    localparam logic [1:0] ADDR_XFER   = 2'd3;

    // Transfer counter width and saturation value
    localparam int unsigned XFER_W = 16;
    localparam logic [XFER_W-1:0] XFER_MAX = '1;

    // Grant index width; covers up to 8 sources
    localparam int unsigned IDX_W = 3;

endpackage

// File: rtl/rgb_led_rr_pick.sv
// Combinational round-robin picker: first requester strictly after i_last, wrapping.
module rgb_led_rr_pick
    import rgb_led_arb_pkg::*;
#(
    parameter int unsigned N_SRC = 4
) (
    input  logic [N_SRC-1:0] i_req,
    input  logic [IDX_W-1:0] i_last,
    output logic [N_SRC-1:0] o_onehot,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    logic [2*N_SRC-1:0] w_dbl;
    logic [N_SRC-1:0]   w_rot;
    logic [IDX_W:0]     w_shift;
    logic [IDX_W:0]     w_off;
    logic [IDX_W:0]     w_sum;
    logic               w_found;

    // Doubling the request vector turns the wrap-around search into a plain shift
    assign w_dbl   = {i_req, i_req};
    assign w_shift = {1'b0, i_last} + (IDX_W + 1)'(1);
    assign w_rot   = N_SRC'(w_dbl >> w_shift);

    // Find lowest set bit of the rotated vector and map it back to a source index
    always_comb begin
        w_found = 1'b0;
        w_off   = '0;
        for (int unsigned o = 0; o < N_SRC; o++) begin
            if (!w_found && w_rot[o]) begin
                w_found = 1'b1;
                w_off   = (IDX_W + 1)'(o);
            end
        end
        // i_last < N_SRC, so the sum is below 2*N_SRC and one subtraction suffices
        w_sum = w_shift + w_off;
        if (w_sum >= (IDX_W + 1)'(N_SRC)) begin
            w_sum = w_sum - (IDX_W + 1)'(N_SRC);
        end
        o_any    = w_found;
        o_idx    = w_sum[IDX_W-1:0];
        o_onehot = w_found ? (N_SRC'(1) << o_idx) : '0;
    end

endmodule

// File: rtl/rgb_led_stream_arbiter.sv
// Round-robin arbiter sharing one 24-bit Avalon-ST RGB sink among N_SRC sources,
// with a programmable grant hold time and an Avalon-MM control/status slave.
module rgb_led_stream_arbiter
    import rgb_led_arb_pkg::*;
#(
    parameter int unsigned       N_SRC        = 4,
    parameter int unsigned       HOLD_W       = 24,
    parameter logic [HOLD_W-1:0] HOLD_DEFAULT = HOLD_W'(24'h07FFFF)
) (
    input  logic                csi_MCLK_clk,
    input  logic                rsi_MRST_reset_n,
    input  logic [N_SRC*24-1:0] asi_SRC_data,
    input  logic [N_SRC-1:0]    asi_SRC_valid,
    output logic [N_SRC-1:0]    asi_SRC_ready,
    output logic [23:0]         aso_LEDS_data,
    output logic                aso_LEDS_valid,
    input  logic                aso_LEDS_ready,
    input  logic [1:0]          avs_CTRL_address,
    input  logic                avs_CTRL_write,
    input  logic [31:0]         avs_CTRL_writedata,
    input  logic                avs_CTRL_read,
    output logic [31:0]         avs_CTRL_readdata
);

    arb_state_e         r_state;
    arb_state_e         w_state_nxt;
    logic [N_SRC-1:0]   r_enable;
    logic [HOLD_W-1:0]  r_hold;
    logic [HOLD_W-1:0]  r_hold_cnt;
    logic               r_hold_unl;
    logic [IDX_W-1:0]   r_grant;
    logic [IDX_W-1:0]   r_last_grant;
    logic [XFER_W-1:0]  r_xfer_cnt;

    logic [N_SRC-1:0]   w_req;
    logic [N_SRC-1:0]   w_unused_pick_onehot;
    logic [IDX_W-1:0]   w_pick_idx;
    logic               w_pick_any;
    logic               w_g_valid;
    logic               w_g_en;
    logic [23:0]        w_g_data;
    logic               w_release;
    logic               w_xfer;
    logic               w_unused_wdata;

    // Only the low bits of the write bus reach a register
    assign w_unused_wdata = ^avs_CTRL_writedata;

    assign w_req  = asi_SRC_valid & r_enable;
    assign w_xfer = aso_LEDS_valid & aso_LEDS_ready;

    rgb_led_rr_pick #(
        .N_SRC (N_SRC)
    ) u_pick (
        .i_req    (w_req),
        .i_last   (r_last_grant),
        .o_onehot (w_unused_pick_onehot),
        .o_idx    (w_pick_idx),
        .o_any    (w_pick_any)
    );

    // Select valid, enable and data of the currently granted source
    always_comb begin
        w_g_valid = 1'b0;
        w_g_en    = 1'b0;
        w_g_data  = '0;
        for (int unsigned k = 0; k < N_SRC; k++) begin
            if (r_grant == IDX_W'(k)) begin
                w_g_valid = asi_SRC_valid[k];
                w_g_en    = r_enable[k];
                w_g_data  = asi_SRC_data[24*k +: 24];
            end
        end
    end

    // Hold expiry uses the unlimited flag latched at grant time, so HOLD writes wait
    assign w_release = !w_g_valid || !w_g_en ||
                       (!r_hold_unl && (r_hold_cnt == HOLD_W'(1)));

    // FSM state register
    always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
        if (!rsi_MRST_reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_pick_any) w_state_nxt = GRANT;
            GRANT:   if (w_release)  w_state_nxt = RELEASE;
            RELEASE: w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Stream outputs: combinational pass-through of the granted source in GRANT only
    always_comb begin
        aso_LEDS_valid = 1'b0;
        aso_LEDS_data  = '0;
        asi_SRC_ready  = '0;
        if (r_state == GRANT) begin
            aso_LEDS_valid = w_g_valid;
            aso_LEDS_data  = w_g_data;
            for (int unsigned k = 0; k < N_SRC; k++) begin
                asi_SRC_ready[k] = (r_grant == IDX_W'(k)) && aso_LEDS_ready;
            end
        end
    end

    // Grant bookkeeping: latch winner and hold length, count down, record last grant
    always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
        if (!rsi_MRST_reset_n) begin
            r_grant      <= '0;
            r_last_grant <= IDX_W'(N_SRC - 1);
            r_hold_cnt   <= '0;
            r_hold_unl   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pick_any) begin
                        r_grant    <= w_pick_idx;
                        r_hold_cnt <= r_hold;
                        r_hold_unl <= (r_hold == '0);
                    end
                end
                GRANT: begin
                    if (!r_hold_unl && (r_hold_cnt != '0)) begin
                        r_hold_cnt <= r_hold_cnt - HOLD_W'(1);
                    end
                end
                RELEASE: r_last_grant <= r_grant;
                default: ;
            endcase
        end
    end

    // Writable control registers
    always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
        if (!rsi_MRST_reset_n) begin
            r_enable <= '1;
            r_hold   <= HOLD_DEFAULT;
        end else if (avs_CTRL_write) begin
            if (avs_CTRL_address == ADDR_ENABLE) r_enable <= avs_CTRL_writedata[N_SRC-1:0];
            if (avs_CTRL_address == ADDR_HOLD)   r_hold   <= avs_CTRL_writedata[HOLD_W-1:0];
        end
    end

    // Saturating transfer counter; a write to its address clears it
    always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
        if (!rsi_MRST_reset_n) begin
            r_xfer_cnt <= '0;
        end else if (avs_CTRL_write && (avs_CTRL_address == ADDR_XFER)) begin
            r_xfer_cnt <= '0;
        end else if (w_xfer && (r_xfer_cnt != XFER_MAX)) begin
            r_xfer_cnt <= r_xfer_cnt + XFER_W'(1);
        end
    end

    // Zero-latency read mux; unused bits read as zero
    always_comb begin
        avs_CTRL_readdata = '0;
        if (avs_CTRL_read) begin
            case (avs_CTRL_address)
                ADDR_ENABLE: avs_CTRL_readdata[N_SRC-1:0]  = r_enable;
                ADDR_HOLD:   avs_CTRL_readdata[HOLD_W-1:0] = r_hold;
                ADDR_STATUS: begin
                    avs_CTRL_readdata[31]        = (r_state == GRANT);
                    avs_CTRL_readdata[IDX_W-1:0] = r_grant;
                end
                ADDR_XFER:   avs_CTRL_readdata[XFER_W-1:0] = r_xfer_cnt;
                default:     ;
            endcase
        end
    end

endmodule

// File: tb/tb_rgb_led_stream_arbiter.sv
// Directed bench for rgb_led_stream_arbiter: per-cycle vector tables plus corner sequences.
module tb_rgb_led_stream_arbiter;

    localparam logic [23:0] D0 = 24'h111111;
    localparam logic [23:0] D1 = 24'h222222;
    localparam logic [23:0] D2 = 24'h333333;
    localparam logic [23:0] D3 = 24'h444444;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [95:0] src_data;
    logic [3:0]  src_valid;
    logic [3:0]  src_ready;
    logic [23:0] leds_data;
    logic        leds_valid;
    logic        leds_ready;
    logic [1:0]  addr;
    logic        wr;
    logic [31:0] wdata;
    logic        rd;
    logic [31:0] rdata;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [3:0]  valid;
        logic        ready;
        logic        exp_v;
        logic [23:0] exp_d;
        logic [3:0]  exp_rdy;
    } vec_t;

    vec_t vecs[$];

    rgb_led_stream_arbiter dut (
        .csi_MCLK_clk       (clk),
        .rsi_MRST_reset_n   (rst_n),
        .asi_SRC_data       (src_data),
        .asi_SRC_valid      (src_valid),
        .asi_SRC_ready      (src_ready),
        .aso_LEDS_data      (leds_data),
        .aso_LEDS_valid     (leds_valid),
        .aso_LEDS_ready     (leds_ready),
        .avs_CTRL_address   (addr),
        .avs_CTRL_write     (wr),
        .avs_CTRL_writedata (wdata),
        .avs_CTRL_read      (rd),
        .avs_CTRL_readdata  (rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] v, input logic r, input logic ev,
                       input logic [23:0] ed, input logic [3:0] er);
        vec_t t;
        t.valid   = v;
        t.ready   = r;
        t.exp_v   = ev;
        t.exp_d   = ed;
        t.exp_rdy = er;
        vecs.push_back(t);
    endtask

    // One vector per cycle: drive at negedge, compare 1 time unit later
    task automatic run_vecs(input string tag);
        foreach (vecs[i]) begin
            @(negedge clk);
            src_valid  = vecs[i].valid;
            leds_ready = vecs[i].ready;
            #1;
            check($sformatf("%s[%0d].valid", tag, i), 32'(leds_valid), 32'(vecs[i].exp_v));
            check($sformatf("%s[%0d].data", tag, i), 32'(leds_data), 32'(vecs[i].exp_d));
            check($sformatf("%s[%0d].ready", tag, i), 32'(src_ready), 32'(vecs[i].exp_rdy));
        end
        vecs.delete();
    endtask

    task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        addr  = a;
        wdata = d;
        wr    = 1'b1;
        @(posedge clk);
        #1;
        wr = 1'b0;
    endtask

    task automatic reg_read(input logic [1:0] a, output logic [31:0] d);
        addr = a;
        rd   = 1'b1;
        #1;
        d  = rdata;
        rd = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n      = 1'b0;
        src_valid  = '0;
        leds_ready = 1'b0;
        wr         = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] r;
        int len[2];
        int streak;
        int nstreak;

        rst_n      = 1'b0;
        src_valid  = '0;
        leds_ready = 1'b0;
        addr       = '0;
        wr         = 1'b0;
        wdata      = '0;
        rd         = 1'b0;
        src_data   = {D3, D2, D1, D0};

        // Reset values
        repeat (2) @(negedge clk);
        check("rst.valid", 32'(leds_valid), 32'd0);
        check("rst.ready", 32'(src_ready), 32'd0);
        rst_n = 1'b1;
        reg_read(2'd0, r); check("rst.enable", r, 32'h0000000F);
        reg_read(2'd1, r); check("rst.hold", r, 32'h0007FFFF);
        reg_read(2'd2, r); check("rst.status", r, 32'h00000000);
        reg_read(2'd3, r); check("rst.xfer", r, 32'h00000000);

        // Sources 0 and 2, HOLD=4: period H+2 per source
        reg_write(2'd1, 32'd4);
        add(4'b0101, 1'b1, 1'b0, '0, 4'b0000);
        for (int i = 0; i < 4; i++) add(4'b0101, 1'b1, 1'b1, D0, 4'b0001);
        add(4'b0101, 1'b1, 1'b0, '0, 4'b0000);
        add(4'b0101, 1'b1, 1'b0, '0, 4'b0000);
        for (int i = 0; i < 4; i++) add(4'b0101, 1'b1, 1'b1, D2, 4'b0100);
        add(4'b0101, 1'b1, 1'b0, '0, 4'b0000);
        add(4'b0101, 1'b1, 1'b0, '0, 4'b0000);
        add(4'b0101, 1'b1, 1'b1, D0, 4'b0001);
        run_vecs("rr02");

        // HOLD=0: source 1 held indefinitely, valid drop releases
        do_reset();
        reg_write(2'd1, 32'd0);
        add(4'b0010, 1'b1, 1'b0, '0, 4'b0000);
        for (int i = 0; i < 4; i++) add(4'b0010, 1'b1, 1'b1, D1, 4'b0010);
        run_vecs("unl_a");
        reg_read(2'd2, r); check("unl.status", r, 32'h80000001);
        for (int i = 0; i < 4; i++) add(4'b0010, 1'b1, 1'b1, D1, 4'b0010);
        add(4'b0000, 1'b1, 1'b0, D1, 4'b0010);
        add(4'b0000, 1'b1, 1'b0, '0, 4'b0000);
        run_vecs("unl_b");
        reg_read(2'd2, r); check("unl.status_rel", r, 32'h00000001);

        // ENABLE=1011 with all valid: order 0,1,3,0
        do_reset();
        reg_write(2'd0, 32'h0000000B);
        reg_write(2'd1, 32'd2);
        reg_read(2'd0, r); check("msk.enable", r, 32'h0000000B);
        add(4'b1111, 1'b1, 1'b0, '0, 4'b0000);
        for (int i = 0; i < 2; i++) add(4'b1111, 1'b1, 1'b1, D0, 4'b0001);
        for (int i = 0; i < 2; i++) add(4'b1111, 1'b1, 1'b0, '0, 4'b0000);
        for (int i = 0; i < 2; i++) add(4'b1111, 1'b1, 1'b1, D1, 4'b0010);
        for (int i = 0; i < 2; i++) add(4'b1111, 1'b1, 1'b0, '0, 4'b0000);
        for (int i = 0; i < 2; i++) add(4'b1111, 1'b1, 1'b1, D3, 4'b1000);
        for (int i = 0; i < 2; i++) add(4'b1111, 1'b1, 1'b0, '0, 4'b0000);
        for (int i = 0; i < 2; i++) add(4'b1111, 1'b1, 1'b1, D0, 4'b0001);
        run_vecs("mask");

        // Sink ready toggling 1,0,1,0,1,0 over a 6-cycle grant: 3 transfers
        do_reset();
        reg_write(2'd1, 32'd6);
        add(4'b0001, 1'b0, 1'b0, '0, 4'b0000);
        for (int i = 0; i < 6; i++) begin
            add(4'b0001, (i % 2 == 0), 1'b1, D0, (i % 2 == 0) ? 4'b0001 : 4'b0000);
        end
        add(4'b0000, 1'b0, 1'b0, '0, 4'b0000);
        run_vecs("rdy");
        reg_read(2'd3, r); check("rdy.xfer", r, 32'd3);
        reg_write(2'd3, 32'd0);
        reg_read(2'd3, r); check("rdy.xfer_clr", r, 32'd0);

        // Reset mid-grant of source 3, then source 0 wins first
        do_reset();
        add(4'b1000, 1'b1, 1'b0, '0, 4'b0000);
        add(4'b1000, 1'b1, 1'b1, D3, 4'b1000);
        add(4'b1000, 1'b1, 1'b1, D3, 4'b1000);
        run_vecs("mrst");
        @(negedge clk);
        rst_n     = 1'b0;
        src_valid = 4'b1111;
        #1;
        check("mrst.valid", 32'(leds_valid), 32'd0);
        check("mrst.data", 32'(leds_data), 32'd0);
        check("mrst.ready", 32'(src_ready), 32'd0);
        reg_read(2'd2, r); check("mrst.status", r, 32'h00000000);
        reg_read(2'd3, r); check("mrst.xfer", r, 32'h00000000);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("mrst.idle_valid", 32'(leds_valid), 32'd0);
        @(negedge clk);
        #1;
        check("mrst.first_data", 32'(leds_data), 32'(D0));
        check("mrst.first_ready", 32'(src_ready), 32'h1);

        // HOLD rewritten 8 -> 2 mid-grant: current grant 8 cycles, next one 2
        do_reset();
        reg_write(2'd1, 32'd8);
        len[0]  = 0;
        len[1]  = 0;
        streak  = 0;
        nstreak = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            src_valid  = 4'b0001;
            leds_ready = 1'b1;
            if (i == 3) begin
                addr  = 2'd1;
                wdata = 32'd2;
                wr    = 1'b1;
            end else begin
                wr = 1'b0;
            end
            #1;
            if (leds_valid) begin
                streak++;
            end else if (streak != 0) begin
                if (nstreak < 2) len[nstreak] = streak;
                nstreak++;
                streak = 0;
            end
        end
        check("hold.streaks_seen", 32'(nstreak >= 2), 32'd1);
        check("hold.first_len", 32'(len[0]), 32'd8);
        check("hold.second_len", 32'(len[1]), 32'd2);
        reg_read(2'd1, r); check("hold.readback", r, 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
